llc_bus_req_queue: RTL and testbench

//  Downstream of the LLC: buffers LLC bus operations (READ/WRITE/INVALIDATE/RWIM), arbitrates for the

---
 rtl/llc_pkg.sv | 44 ++++
 rtl/llc_req_fifo.sv | 50 +++++
 rtl/llc_bus_req_queue.sv | 143 ++++++++++++++
 tb/tb_llc_bus_req_queue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_pkg.sv
// Shared types for the LLC and its bus request queue: bus operation and
// snoop result encodings, FSM state, and small helpers.
package llc_pkg;

    localparam int ADDR_BITS_DEF = 32;

    typedef enum logic [1:0] {
        OP_READ       = 2'd0,
        OP_WRITE      = 2'd1,
        OP_INVALIDATE = 2'd2,
        OP_RWIM       = 2'd3
    } bus_op_t;

    typedef enum logic [1:0] {
        SNP_HIT   = 2'd0,
        SNP_HITM  = 2'd1,
        SNP_NOHIT = 2'd2
    } snp_rslt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_SNOOP,
        ST_XFER,
        ST_RESP
    } state_e;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // The unused encoding 2'b11 on the bus is treated as nobody holding the line.
    function automatic snp_rslt_t snp_decode(input logic [1:0] raw);
        snp_rslt_t r;
        case (raw)
            2'd0:    r = SNP_HIT;
            2'd1:    r = SNP_HITM;
            default: r = SNP_NOHIT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/llc_req_fifo.sv
// Synchronous request FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate occupancy counter.
module llc_req_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // A pop frees the head slot in the same cycle, so a push alongside it is accepted even when full.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer update; wraps naturally modulo 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents are don't-care until pointed at, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/llc_bus_req_queue.sv
// Buffers LLC bus operations, runs them one at a time on the system bus,
// retries READ/RWIM after a HITM snoop, and returns a completion pulse.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no op in flight; pop FIFO head when present
// ST_ARB   | bus_req asserted, waiting for bus_gnt
// ST_SNOOP | bus owned, waiting for the combined snoop strobe
// ST_XFER  | waiting for bus_done; decide retry or complete
// ST_RESP  | rsp_valid high for this single cycle
module llc_bus_req_queue
    import llc_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [ADDR_BITS-1:0] req_addr,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_op,
    output logic [ADDR_BITS-1:0] rsp_addr,
    output logic [1:0]           rsp_snoop,
    output logic                 bus_req,
    output logic [1:0]           bus_op,
    output logic [ADDR_BITS-1:0] bus_addr,
    input  logic                 bus_gnt,
    input  logic                 bus_snoop_valid,
    input  logic [1:0]           bus_snoop,
    input  logic                 bus_done,
    output logic [31:0]          ops_issued,
    output logic [31:0]          retries
);

    state_e                 state;
    bus_op_t                cur_op;
    logic [ADDR_BITS-1:0]   cur_addr;
    snp_rslt_t              cur_snp;
    logic [3:0]             retry_cnt;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [ADDR_BITS+1:0]   fifo_rdata;
    logic                   retry_now;

    assign req_ready = !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign bus_op    = cur_op;
    assign bus_addr  = cur_addr;
    assign retry_now = ((cur_op == OP_READ) || (cur_op == OP_RWIM)) &&
                       (cur_snp == SNP_HITM) && (retry_cnt < 4'(MAX_RETRY));

    llc_req_fifo #(
        .WIDTH (2 + ADDR_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid && req_ready),
        .wdata ({req_op, req_addr}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Transaction FSM with registered bus/response outputs and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur_op     <= OP_READ;
            cur_addr   <= '0;
            cur_snp    <= SNP_HIT;
            retry_cnt  <= '0;
            bus_req    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_op     <= '0;
            rsp_addr   <= '0;
            rsp_snoop  <= '0;
            ops_issued <= '0;
            retries    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_op    <= bus_op_t'(fifo_rdata[ADDR_BITS+1:ADDR_BITS]);
                        cur_addr  <= fifo_rdata[ADDR_BITS-1:0];
                        retry_cnt <= '0;
                        bus_req   <= 1'b1;
                        state     <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (bus_gnt) begin
                        bus_req    <= 1'b0;
                        ops_issued <= sat_inc(ops_issued);
                        state      <= ST_SNOOP;
                    end
                end
                ST_SNOOP: begin
                    if (bus_snoop_valid) begin
                        cur_snp <= snp_decode(bus_snoop);
                        // Invalidates carry no data phase, so they complete straight from the snoop.
                        if (cur_op == OP_INVALIDATE) begin
                            rsp_valid <= 1'b1;
                            rsp_op    <= cur_op;
                            rsp_addr  <= cur_addr;
                            rsp_snoop <= snp_decode(bus_snoop);
                            state     <= ST_RESP;
                        end else begin
                            state <= ST_XFER;
                        end
                    end
                end
                ST_XFER: begin
                    if (bus_done) begin
                        if (retry_now) begin
                            retry_cnt <= retry_cnt + 4'd1;
                            retries   <= sat_inc(retries);
                            bus_req   <= 1'b1;
                            state     <= ST_ARB;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_op    <= cur_op;
                            rsp_addr  <= cur_addr;
                            rsp_snoop <= cur_snp;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_llc_bus_req_queue.sv
// Directed bench for llc_bus_req_queue: a bus-side driver serves each op,
// expected completions are queued at push time and checked by a monitor.
module tb_llc_bus_req_queue;
    import llc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [1:0]  rsp_op;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_snoop;
    logic        bus_req;
    logic [1:0]  bus_op;
    logic [31:0] bus_addr;
    logic        bus_gnt;
    logic        bus_snoop_valid;
    logic [1:0]  bus_snoop;
    logic        bus_done;
    logic [31:0] ops_issued;
    logic [31:0] retries;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [1:0]  snp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    llc_bus_req_queue #(.ADDR_BITS(32), .DEPTH(4), .MAX_RETRY(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .rsp_valid       (rsp_valid),
        .rsp_op          (rsp_op),
        .rsp_addr        (rsp_addr),
        .rsp_snoop       (rsp_snoop),
        .bus_req         (bus_req),
        .bus_op          (bus_op),
        .bus_addr        (bus_addr),
        .bus_gnt         (bus_gnt),
        .bus_snoop_valid (bus_snoop_valid),
        .bus_snoop       (bus_snoop),
        .bus_done        (bus_done),
        .ops_issued      (ops_issued),
        .retries         (retries)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got op=%0d addr=%0h snp=%0d expected none",
                         rsp_op, rsp_addr, rsp_snoop);
            end else begin
                e = sb.pop_front();
                chk("rsp_op", 64'(rsp_op), 64'(e.op));
                chk("rsp_addr", 64'(rsp_addr), 64'(e.addr));
                chk("rsp_snoop", 64'(rsp_snoop), 64'(e.snp));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_op = '0; req_addr = '0;
        bus_gnt = 1'b0; bus_snoop_valid = 1'b0; bus_snoop = '0; bus_done = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One-cycle push; the expected completion is queued when record is set.
    task automatic push(input logic [1:0] op, input logic [31:0] addr,
                        input logic [1:0] snp_exp, input bit record);
        req_valid = 1'b1; req_op = op; req_addr = addr;
        if (record) sb.push_back('{op: op, addr: addr, snp: snp_exp});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Bus-side agent: wait for the request, grant, strobe snoop, then done.
    task automatic serve(input logic [1:0] op, input logic [31:0] addr, input logic [1:0] snp,
                         input bit do_snoop, input bit do_done, input int gnt_delay);
        int n = 0;
        while (!bus_req && n < 50) begin @(negedge clk); n++; end
        if (!bus_req) begin
            checks++; errors++;
            $display("FAIL bus_req_wait: got 0 expected 1 within 50 cycles");
            return;
        end
        chk("bus_op", 64'(bus_op), 64'(op));
        chk("bus_addr", 64'(bus_addr), 64'(addr));
        repeat (gnt_delay) @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        chk("bus_req_after_gnt", 64'(bus_req), 64'd0);
        if (!do_snoop) return;
        bus_snoop_valid = 1'b1; bus_snoop = snp;
        @(negedge clk);
        bus_snoop_valid = 1'b0; bus_snoop = '0;
        if (do_done) begin
            bus_done = 1'b1;
            @(negedge clk);
            bus_done = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        apply_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_ops_issued", 64'(ops_issued), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // 1: READ, grant after 3 cycles, NOHIT
        push(OP_READ, 32'h0000_1000, SNP_NOHIT, 1'b1);
        serve(OP_READ, 32'h0000_1000, SNP_NOHIT, 1'b1, 1'b1, 3);
        wait_drain();
        chk("t1_ops_issued", 64'(ops_issued), 64'd1);

        // 2: RWIM, HITM twice then HIT
        apply_reset();
        push(OP_RWIM, 32'h40, SNP_HIT, 1'b1);
        serve(OP_RWIM, 32'h40, SNP_HITM, 1'b1, 1'b1, 0);
        serve(OP_RWIM, 32'h40, SNP_HITM, 1'b1, 1'b1, 1);
        serve(OP_RWIM, 32'h40, SNP_HIT,  1'b1, 1'b1, 0);
        wait_drain();
        chk("t2_retries", 64'(retries), 64'd2);
        chk("t2_ops_issued", 64'(ops_issued), 64'd3);

        // 3: READ, HITM every time; gives up after 3 retries
        apply_reset();
        push(OP_READ, 32'h80, SNP_HITM, 1'b1);
        for (int i = 0; i < 4; i++) serve(OP_READ, 32'h80, SNP_HITM, 1'b1, 1'b1, 0);
        wait_drain();
        chk("t3_retries", 64'(retries), 64'd3);
        chk("t3_ops_issued", 64'(ops_issued), 64'd4);

        // 4: INVALIDATE completes one cycle after the snoop strobe, no bus_done
        apply_reset();
        push(OP_INVALIDATE, 32'hC0, SNP_HIT, 1'b1);
        serve(OP_INVALIDATE, 32'hC0, SNP_HIT, 1'b1, 1'b0, 0);
        chk("t4_rsp_after_strobe", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        chk("t4_rsp_one_cycle", 64'(rsp_valid), 64'd0);
        wait_drain();

        // 5: fill with grant held low. The first op leaves the FIFO for ARB,
        //    so four more fill it: ready drops after the fifth push, sixth dropped.
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            chk("t5_req_ready", 64'(req_ready), (i < 5) ? 64'd1 : 64'd0);
            push(2'(i), 32'h500 + 32'(i) * 32'h40, SNP_NOHIT, (i < 5));
        end
        for (int i = 0; i < 5; i++)
            serve(2'(i), 32'h500 + 32'(i) * 32'h40, SNP_NOHIT, 1'b1, 1'b1, 0);
        wait_drain();
        repeat (4) @(negedge clk);
        chk("t5_no_extra_req", 64'(bus_req), 64'd0);
        chk("t5_ops_issued", 64'(ops_issued), 64'd5);

        // 6: reset while in SNOOP drops everything, then a fresh READ works
        apply_reset();
        push(OP_READ, 32'h300, SNP_NOHIT, 1'b0);
        serve(OP_READ, 32'h300, SNP_NOHIT, 1'b0, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_bus_req", 64'(bus_req), 64'd0);
        chk("t6_ops_issued", 64'(ops_issued), 64'd0);
        chk("t6_bus_addr", 64'(bus_addr), 64'd0);
        chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t6_req_ready", 64'(req_ready), 64'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_fifo_empty", 64'(bus_req), 64'd0);
        push(OP_READ, 32'h400, SNP_NOHIT, 1'b1);
        serve(OP_READ, 32'h400, SNP_NOHIT, 1'b1, 1'b1, 1);
        wait_drain();
        chk("t6_ops_issued_after", 64'(ops_issued), 64'd1);

        // 7: WRITE with HITM is reported as-is, never retried
        apply_reset();
        push(OP_WRITE, 32'h100, SNP_HITM, 1'b1);
        serve(OP_WRITE, 32'h100, SNP_HITM, 1'b1, 1'b1, 0);
        wait_drain();
        repeat (3) @(negedge clk);
        chk("t7_retries", 64'(retries), 64'd0);
        chk("t7_bus_req", 64'(bus_req), 64'd0);

        // 8: illegal snoop encoding 2'b11 reads back as NOHIT
        apply_reset();
        push(OP_READ, 32'h140, SNP_NOHIT, 1'b1);
        serve(OP_READ, 32'h140, 2'b11, 1'b1, 1'b1, 0);
        wait_drain();
        chk("t8_retries", 64'(retries), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
